// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width, requester-count range.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping NUM_REQ-1 -> 0.
// Latency: combinational.
// Backpressure: none; winner is only meaningful while any_req is high.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        // Scan farthest-first so the requester closest to ptr is the last to overwrite winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing one byte at a time from NUM_REQ requesters to an 8N1 transmitter; UART_TX_ARB_LOCK_EN adds req_last message locking.
// Latency: trans_write one cycle after a qualifying IDLE cycle; strobe spacing is transmitter busy time + 2.
// Backpressure: no grant while trans_busy is high; requesters hold valid/data until their one-cycle req_ack.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                           clk_baud_16x,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_last,
`endif
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [UART_BYTE_W-1:0]         trans_data,
    output logic                           trans_write,
    input  logic                           trans_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           arb_busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [UART_BYTE_W-1:0] trans_data_q, trans_data_d;
    logic                   trans_write_q, trans_write_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]     elig;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
`ifdef UART_TX_ARB_LOCK_EN
    logic                   lock_q, lock_d;

    // While locked only the last granted requester may compete; grant_id_q still names it.
    assign elig = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id_q)) : req_valid;
`else
    assign elig = req_valid;
`endif

    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (elig),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        trans_data_d  = trans_data_q;
        trans_write_d = 1'b0;
        req_ack_d     = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d        = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req && !trans_busy) begin
                    state_d       = ISSUE;
                    trans_write_d = 1'b1;
                    req_ack_d     = NUM_REQ'(1) << winner;
                    trans_data_d  = req_data[int'(winner)*UART_BYTE_W +: UART_BYTE_W];
                    grant_id_d    = winner;
                    ptr_d         = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d        = ~req_last[winner];
`endif
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (!trans_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_baud_16x or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            trans_data_q  <= '0;
            trans_write_q <= 1'b0;
            req_ack_q     <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            trans_data_q  <= trans_data_d;
            trans_write_q <= trans_write_d;
            req_ack_q     <= req_ack_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q        <= lock_d;
`endif
        end
    end

    assign req_ack     = req_ack_q;
    assign trans_data  = trans_data_q;
    assign trans_write = trans_write_q;
    assign grant_id    = grant_id_q;
    assign arb_busy    = (state_q != IDLE) || trans_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a transmitter whose busy covers BUSY_CYC cycles from the strobe,
// and a transaction-level model checked every cycle, plus literal checks of the scenario outcomes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int BUSY_CYC = 5;
    localparam int SPACING  = BUSY_CYC + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '1;
    logic [N-1:0]   req_ack;
    logic [7:0]     trans_data;
    logic           trans_write;
    logic           trans_busy;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           force_busy = 1'b0;
    int             tx_cnt = 0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]   bq [N][$];
    logic         lq [N][$];
    logic [N-1:0] ack_seen = '0;

    int         wr_cyc [$];
    int         wr_id  [$];
    int         wr_dat [$];

    // model state
    bit           m_pend = 1'b0;
    bit           m_idle = 1'b1;
    bit           m_lock = 1'b0;
    bit           wr_now;
    int           m_pw = 0;
    int           m_ptr = 0;
    int           m_gid = 0;
    int           w;
    logic [7:0]   m_pdata = '0;
    logic [N-1:0] elig;
    logic [N-1:0] exp_ack;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk_baud_16x (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_last     (req_last),
`endif
        .req_ack      (req_ack),
        .trans_data   (trans_data),
        .trans_write  (trans_write),
        .trans_busy   (trans_busy),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (trans_write) tx_cnt <= BUSY_CYC - 1;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign trans_busy = force_busy | trans_write | (tx_cnt > 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic int log_id(input int i);
        return (i < wr_id.size()) ? wr_id[i] : -1;
    endfunction
    function automatic int log_cyc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction
    function automatic int log_dat(input int i);
        return (i < wr_dat.size()) ? wr_dat[i] : -1;
    endfunction

    // Per-cycle compare against the model; inputs are stable at the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (trans_write === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_id.push_back(int'(grant_id));
            wr_dat.push_back(int'(trans_data));
        end
        ack_seen = ack_seen | req_ack;
        if (rst) begin
            chk("rst_write", trans_write, 0);
            chk("rst_ack", req_ack, 0);
            chk("rst_data", trans_data, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_arb_busy", arb_busy, trans_busy);
            m_pend = 1'b0; m_idle = 1'b1; m_lock = 1'b0; m_ptr = 0; m_gid = 0;
        end else begin
            wr_now = m_pend;
            if (wr_now) begin
                m_idle = 1'b0;
                m_gid  = m_pw;
            end
            exp_ack = wr_now ? (N'(1) << m_pw) : '0;
            chk("write", trans_write, wr_now);
            chk("ack", req_ack, exp_ack);
            chk("grant_id", grant_id, m_gid);
            chk("arb_busy", arb_busy, (!m_idle) || trans_busy);
            if (wr_now) chk("data", trans_data, m_pdata);
            elig = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
            if (m_lock) elig = req_valid & (N'(1) << m_gid);
`endif
            m_pend = 1'b0;
            if (m_idle && !trans_busy && elig != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_pend  = 1'b1;
                m_pw    = w;
                m_pdata = req_data[w*8 +: 8];
                m_ptr   = (w + 1) % N;
`ifdef UART_TX_ARB_LOCK_EN
                m_lock  = !req_last[w];
`endif
            end
            // a non-busy cycle after the strobe cycle returns the arbiter to idle next cycle
            if (!wr_now && !trans_busy) m_idle = 1'b1;
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = bq[i].size() > 0;
            req_data[i*8 +: 8] = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
            req_last[i]       = (lq[i].size() > 0) ? lq[i][0] : 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && bq[i].size() > 0) begin
                void'(bq[i].pop_front());
                void'(lq[i].pop_front());
            end
        end
        ack_seen = '0;
        drive_reqs();
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        bq[r].push_back(d);
        lq[r].push_back(last);
    endtask

    function automatic bit queues_busy();
        for (int i = 0; i < N; i++) if (bq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int k = 0;
        while ((arb_busy || queues_busy()) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) fail_now("drain");
        tick();
        tick();
    endtask

    task automatic wait_writes(input int target, input int budget);
        int k = 0;
        while (wr_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        if (wr_cyc.size() < target) fail_now("write_wait");
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    int exp_lock_id  [4] = '{1, 1, 1, 0};
    int exp_lock_dat [4] = '{8'h61, 8'h62, 8'h63, 8'h50};
    int exp_hold_wr      = 1;
`else
    int exp_lock_id  [4] = '{1, 0, 1, 1};
    int exp_lock_dat [4] = '{8'h61, 8'h50, 8'h62, 8'h63};
    int exp_hold_wr      = 2;
`endif
    int exp_fair_id  [5] = '{0, 1, 2, 3, 0};

    initial begin
        int base, t0, nb;
        rst = 1'b1;
        #1;
        chk("por_write", trans_write, 0);
        chk("por_data", trans_data, 0);
        chk("por_ack", req_ack, 0);
        chk("por_grant_id", grant_id, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // fairness: everyone valid with two bytes each
        base = wr_cyc.size();
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < N; i++) push(i, 8'h20 + 8'(i), 1'b1);
        drive_reqs();
        t0 = cyc + 1;
        wait_writes(base + 8, 300);
        for (int k = 0; k < 5; k++) chk("fair_order", log_id(base + k), exp_fair_id[k]);
        chk("fair_latency", log_cyc(base), t0 + 1);
        for (int k = 0; k < 4; k++) chk("fair_spacing", log_cyc(base + k + 1) - log_cyc(base + k), SPACING);
        chk("fair_data0", log_dat(base), 8'h10);
        chk("fair_data4", log_dat(base + 4), 8'h20);
        drain();

        // single request
        base = wr_cyc.size();
        push(2, 8'hA5, 1'b1);
        drive_reqs();
        t0 = cyc + 1;
        wait_writes(base + 1, 50);
        chk("single_id", log_id(base), 2);
        chk("single_data", log_dat(base), 8'hA5);
        chk("single_latency", log_cyc(base), t0 + 1);
        drain();
        chk("single_id_held", grant_id, 2);

        // busy hold-off
        base = wr_cyc.size();
        force_busy = 1'b1;
        push(0, 8'h3C, 1'b1);
        drive_reqs();
        repeat (15) tick();
        chk("holdoff_no_write", wr_cyc.size(), base);
        force_busy = 1'b0;
        t0 = cyc + 1;
        wait_writes(base + 1, 50);
        chk("holdoff_latency", log_cyc(base), t0 + 1);
        chk("holdoff_id", log_id(base), 0);
        drain();

        // reset during WAIT: requester 1 granted, pointer would favour 3 over 0
        base = wr_cyc.size();
        push(1, 8'h41, 1'b1);
        drive_reqs();
        wait_writes(base + 1, 50);
        push(0, 8'h0A, 1'b1);
        push(3, 8'hD3, 1'b1);
        drive_reqs();
        tick();
        rst = 1'b1;
        #1;
        chk("wait_rst_write", trans_write, 0);
        chk("wait_rst_ack", req_ack, 0);
        chk("wait_rst_data", trans_data, 0);
        chk("wait_rst_grant_id", grant_id, 0);
        nb = wr_cyc.size();
        repeat (3) tick();
        chk("wait_rst_no_strobe", wr_cyc.size(), nb);
        rst = 1'b0;
        wait_writes(nb + 1, 50);
        chk("wait_rst_winner", log_id(nb), 0);
        chk("wait_rst_data_next", log_dat(nb), 8'h0A);
        drain();

        // message lock: requester 1 starts a 3-byte message, requester 0 competes
        base = wr_cyc.size();
        push(1, 8'h61, 1'b0);
        drive_reqs();
        wait_writes(base + 1, 50);
        push(0, 8'h50, 1'b1);
        drive_reqs();
        repeat (20) tick();
        chk("lock_hold", wr_cyc.size() - base, exp_hold_wr);
        push(1, 8'h62, 1'b0);
        push(1, 8'h63, 1'b1);
        drive_reqs();
        wait_writes(base + 4, 100);
        for (int k = 0; k < 4; k++) begin
            chk("lock_order", log_id(base + k), exp_lock_id[k]);
            chk("lock_data", log_dat(base + k), exp_lock_dat[k]);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
